// File: rtl/pool_pkg.sv
// Shared types and default sizes for the pooling window reducer.
package pool_pkg;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 4;
  localparam int WIN_N  = 4;
  localparam int ACC_W  = DATA_W + 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_FLUSH = 2'd2,
    ST_OUT   = 2'd3
  } state_e;

  // Right shift that turns a window sum into its floored average.
  function automatic int win_shift(input int n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/pool_reduce_acc.sv
// Window accumulator: running signed max, or running sum when POOL_AVG_EN is defined.
// clear starts a new window, enable folds in one sample, mode selects average (1) or max (0).
module pool_reduce_acc
  import pool_pkg::*;
#(
  parameter int data_width = DATA_W,
  parameter int win_n      = WIN_N
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  clear,
  input  logic                  enable,
  input  logic [data_width-1:0] sample,
  input  logic                  mode,
  output logic [data_width-1:0] result
);

`ifdef POOL_AVG_EN
  // Two guard bits hold the sum of up to four full-scale entries.
  localparam int AW    = data_width + (ACC_W - DATA_W);
  localparam int SHIFT = win_shift(win_n);
`else
  localparam int AW = data_width;
`endif

  logic signed [AW-1:0] acc_q, acc_d;
  logic                 first_q, first_d;
  logic signed [AW-1:0] sample_ext;

  assign sample_ext = AW'($signed(sample));

  always_comb begin
    acc_d   = acc_q;
    first_d = first_q;
    if (clear) begin
      acc_d   = '0;
      first_d = 1'b1;
    end else if (enable) begin
      first_d = 1'b0;
`ifdef POOL_AVG_EN
      if (mode) begin
        acc_d = acc_q + sample_ext;
      end else if (first_q || (sample_ext > acc_q)) begin
        acc_d = sample_ext;
      end
`else
      // The first entry is always taken so an all-negative window is not clamped to zero.
      if (first_q || (sample_ext > acc_q)) begin
        acc_d = sample_ext;
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      acc_q   <= '0;
      first_q <= 1'b1;
    end else begin
      acc_q   <= acc_d;
      first_q <= first_d;
    end
  end

`ifdef POOL_AVG_EN
  assign result = mode ? data_width'(acc_q >>> SHIFT) : acc_q[data_width-1:0];
`else
  logic unused_mode;
  assign unused_mode = mode;
  assign result      = acc_q;
`endif

endmodule

// File: rtl/pool_window_reduce.sv
// Pooling window reducer: reads win_n consecutive register-file entries and presents their
// max (or average, with POOL_AVG_EN defined) through a valid/ready output.
module pool_window_reduce
  import pool_pkg::*;
#(
  parameter int data_width  = DATA_W,
  parameter int address_num = ADDR_W,
  parameter int win_n       = WIN_N
) (
  input  logic                   clk,
  input  logic                   nrst,
  input  logic                   start,
  input  logic [address_num-1:0] base_adrs,
  input  logic [data_width-1:0]  rd_data,
  output logic [address_num-1:0] rd_adrs,
  output logic [data_width-1:0]  out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
`ifdef POOL_AVG_EN
  input  logic                   avg_mode,
`endif
  output logic                   busy
);

  localparam int            CW       = $clog2(win_n);
  localparam logic [CW-1:0] CNT_LAST = CW'(win_n - 1);

  state_e                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [address_num-1:0] rd_adrs_q, rd_adrs_d;
  logic                   acc_clear;
  logic                   acc_en;
  logic                   acc_mode;

`ifdef POOL_AVG_EN
  logic mode_q, mode_d;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rd_adrs_d = rd_adrs_q;
    acc_clear = 1'b0;
    acc_en    = 1'b0;
`ifdef POOL_AVG_EN
    mode_d    = mode_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_FETCH;
          cnt_d     = '0;
          rd_adrs_d = base_adrs;
          acc_clear = 1'b1;
`ifdef POOL_AVG_EN
          mode_d    = avg_mode;
`endif
        end
      end
      ST_FETCH: begin
        // Read data trails the address by one cycle, so cnt=0 has nothing to sample yet.
        acc_en = (cnt_q != '0);
        if (cnt_q == CNT_LAST) begin
          state_d = ST_FLUSH;
          cnt_d   = '0;
        end else begin
          cnt_d     = cnt_q + 1'b1;
          rd_adrs_d = rd_adrs_q + 1'b1;
        end
      end
      ST_FLUSH: begin
        acc_en  = 1'b1;
        state_d = ST_OUT;
      end
      ST_OUT: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      rd_adrs_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rd_adrs_q <= rd_adrs_d;
    end
  end

`ifdef POOL_AVG_EN
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      mode_q <= 1'b0;
    end else begin
      mode_q <= mode_d;
    end
  end
  assign acc_mode = mode_q;
`else
  assign acc_mode = 1'b0;
`endif

  // The accumulator is only touched between start and OUT, so its result doubles as out_data.
  pool_reduce_acc #(
    .data_width(data_width),
    .win_n     (win_n)
  ) u_acc (
    .clk   (clk),
    .nrst  (nrst),
    .clear (acc_clear),
    .enable(acc_en),
    .sample(rd_data),
    .mode  (acc_mode),
    .result(out_data)
  );

  assign rd_adrs   = rd_adrs_q;
  assign out_valid = (state_q == ST_OUT);
  assign busy      = (state_q != ST_IDLE);

endmodule
